lc3_mem_arbiter: RTL and testbench

Memory-access sequencer that shares the single LC-3 memory port between the CPU control unit's memory cycle (MIO.EN / R.W, waited on via R in the fetch and load/store wait states) and a DMA requester. It owns the memory-port handshake, counts out a fixed memory latency and returns the one-cycle ready pulse R to whichever requester was granted. It sits between the control/datapath (MAR/MDR) and the memory array.

---
 rtl/lc3_mem_arbiter_if.sv | 23 ++
 rtl/lc3_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_arbiter_if.sv
// Requester-side memory handshake: req/we/addr/wdata in, rdata and a
// one-cycle ready pulse back. Shared by the CPU and DMA ports.
interface lc3_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, rdy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, rdy
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory port sequencer shared by CPU and DMA, fixed MEM_LAT access.
// Define LC3_ARB_FAIR_EN for round-robin ties; default is CPU priority.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  lc3_mem_arbiter_if.slave  cpu,
  lc3_mem_arbiter_if.slave  dma,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_own_dma;
  logic              r_en;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_cpu_r;
  logic              r_dma_ack;

  logic              w_any;
  logic              w_tie_dma;
  logic              w_pick_dma;

`ifdef LC3_ARB_FAIR_EN
  logic r_prio_dma;

  // Pointer names the side that wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_dma <= 1'b0;
    end else if (r_state == S_IDLE && w_any) begin
      r_prio_dma <= ~w_pick_dma;
    end
  end

  assign w_tie_dma = r_prio_dma;
`else
  assign w_tie_dma = 1'b0;
`endif

  assign w_any = cpu.req | dma.req;

  always_comb begin
    w_pick_dma = 1'b0;
    unique case (1'b1)
      (cpu.req & dma.req):  w_pick_dma = w_tie_dma;
      (dma.req & ~cpu.req): w_pick_dma = 1'b1;
      default:              w_pick_dma = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_own_dma   <= 1'b0;
      r_en        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_r     <= 1'b0;
      r_dma_ack   <= 1'b0;
    end else begin
      r_cpu_r   <= 1'b0;
      r_dma_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_own_dma <= w_pick_dma;
            r_we      <= w_pick_dma ? dma.we    : cpu.we;
            r_addr    <= w_pick_dma ? dma.addr  : cpu.addr;
            r_wdata   <= w_pick_dma ? dma.wdata : cpu.wdata;
            r_cnt     <= LAT_M1;
            r_en      <= 1'b1;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_en    <= 1'b0;
            r_state <= S_DONE;
            if (r_own_dma) begin
              r_dma_ack <= 1'b1;
              if (!r_we) r_dma_rdata <= mem_rdata;
            end else begin
              r_cpu_r <= 1'b1;
              if (!r_we) r_cpu_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = r_en;
  assign mem_we    = r_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);

  assign cpu.rdata = r_cpu_rdata;
  assign cpu.rdy   = r_cpu_r;
  assign dma.rdata = r_dma_rdata;
  assign dma.rdy   = r_dma_ack;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Randomized bench for lc3_mem_arbiter with a transaction-level memory
// model and directed latency, arbitration and reset scenarios.
module tb_lc3_mem_arbiter;

  localparam int LAT  = 2;
  localparam int LAT1 = 1;
`ifdef LC3_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem1_en, mem1_we, busy1;
  logic [15:0] mem1_addr, mem1_wdata, mem1_rdata;

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dma_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu1_if ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dma1_if ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu_if),
    .dma       (dma_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu1_if),
    .dma       (dma1_if),
    .mem_en    (mem1_en),
    .mem_we    (mem1_we),
    .mem_addr  (mem1_addr),
    .mem_wdata (mem1_wdata),
    .mem_rdata (mem1_rdata),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] tb_mem  [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          en_cnt;

  // Memory only presents real data on the final enable cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_cnt <= 0;
    else        en_cnt <= mem_en ? en_cnt + 1 : 0;
  end

  assign mem_rdata  = (mem_en && en_cnt == LAT - 1) ?
                      tb_mem[mem_addr] : (mem_addr ^ 16'hA5A5);
  assign mem1_rdata = mem1_en ? tb_mem[mem1_addr] : 16'h0;

  int          n_cmp, n_bad, cyc, en_run;
  logic [15:0] exp_cpu_rd, exp_dma_rd;
  logic        acc_we;
  logic [15:0] acc_addr, acc_wdata;
  logic [1:0]  rdy_seen;
  logic        prev_c, prev_d;
  int          order_q [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int w, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    if (w == 0) begin
      cpu_if.req = req; cpu_if.we = we;
      cpu_if.addr = a;  cpu_if.wdata = d;
    end else begin
      dma_if.req = req; dma_if.we = we;
      dma_if.addr = a;  dma_if.wdata = d;
    end
  endtask

  task automatic finish_acc(input int w);
    logic        we;
    logic [15:0] a, d;
    we = (w == 0) ? cpu_if.we    : dma_if.we;
    a  = (w == 0) ? cpu_if.addr  : dma_if.addr;
    d  = (w == 0) ? cpu_if.wdata : dma_if.wdata;
    check("en_cycles", en_run, LAT);
    check("busy_done", busy, 1);
    check("acc_addr", acc_addr, a);
    check("acc_we", acc_we, we);
    if (we) begin
      check("acc_wdata", acc_wdata, d);
      ref_mem[a] = d;
    end else if (w == 0) begin
      exp_cpu_rd = ref_mem[a];
    end else begin
      exp_dma_rd = ref_mem[a];
    end
    en_run = 0;
    rdy_seen[w] = 1'b1;
    order_q.push_back(w);
  endtask

  task automatic tick();
    logic c, d;
    @(negedge clk);
    cyc++;
    c = cpu_if.rdy;
    d = dma_if.rdy;
    check("rdy_excl", c & d, 0);
    if (c) check("cpu_r_1cyc", prev_c, 0);
    if (d) check("dma_ack_1cyc", prev_d, 0);
    prev_c = c;
    prev_d = d;
    if (mem_en) begin
      check("busy_acc", busy, 1);
      if (en_run == 0) begin
        acc_we = mem_we; acc_addr = mem_addr; acc_wdata = mem_wdata;
      end else begin
        check("stable_addr", mem_addr, acc_addr);
        check("stable_we", mem_we, acc_we);
        if (acc_we) check("stable_wdata", mem_wdata, acc_wdata);
      end
      if (mem_we) tb_mem[mem_addr] = mem_wdata;
      en_run++;
    end
    if (c) finish_acc(0);
    if (d) finish_acc(1);
    check("cpu_rdata", cpu_if.rdata, exp_cpu_rd);
    check("dma_rdata", dma_if.rdata, exp_dma_rd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);
    exp_cpu_rd = '0; exp_dma_rd = '0;
    en_run = 0; rdy_seen = '0;
    tick();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_r", cpu_if.rdy, 0);
    check("rst_dma_ack", dma_if.rdy, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic xfer(input int w, input logic we, input logic [15:0] a,
                      input logic [15:0] d, output int lat);
    int t0;
    logic done;
    t0 = cyc;
    done = 1'b0;
    drive(w, 1, we, a, d);
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (rdy_seen[1-w]) begin
        check("wrong_rdy", rdy_seen[1-w], 0);
        rdy_seen[1-w] = 1'b0;
      end
      if (rdy_seen[w]) begin
        done = 1'b1;
        rdy_seen[w] = 1'b0;
      end
    end
    lat = cyc - t0;
    drive(w, 0, 0, 16'h0, 16'h0);
    check("xfer_done", done, 1);
    tick();
  endtask

  initial begin
    int lat, ptr, n, guard, t0, en1;
    int rc [3];
    logic got;
    logic act [2];
    int wt [2];
    n_cmp = 0; n_bad = 0; cyc = 0; en_run = 0;
    prev_c = 0; prev_d = 0; rdy_seen = '0;
    rst_n = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);
    cpu1_if.req = 0; cpu1_if.we = 0; cpu1_if.addr = 0; cpu1_if.wdata = 0;
    dma1_if.req = 0; dma1_if.we = 0; dma1_if.addr = 0; dma1_if.wdata = 0;
    for (int i = 0; i < 65536; i++) begin
      tb_mem[i]  = 16'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;

    do_reset();

    xfer(0, 0, 16'h3000, 16'h0, lat);
    check("cpu_rd_lat", lat, LAT + 1);
    check("cpu_rd_val", cpu_if.rdata, 16'h1234);
    xfer(1, 1, 16'h4000, 16'hBEEF, lat);
    check("dma_wr_lat", lat, LAT + 1);
    check("dma_wr_mem", tb_mem[16'h4000], 16'hBEEF);
    check("cpu_rd_hold", cpu_if.rdata, 16'h1234);
    xfer(1, 0, 16'h4000, 16'h0, lat);
    check("dma_rd_val", dma_if.rdata, 16'hBEEF);

    // Both requesters hammer the port right after reset.
    do_reset();
    order_q.delete();
    drive(0, 1, 0, 16'h3000 + 16'($urandom_range(0, 15)), 16'h0);
    drive(1, 1, 0, 16'h3000 + 16'($urandom_range(0, 15)), 16'h0);
    guard = 0;
    while (order_q.size() < 4 && guard < 200) begin
      tick();
      guard++;
      for (int w = 0; w < 2; w++) begin
        if (rdy_seen[w]) begin
          rdy_seen[w] = 1'b0;
          if (order_q.size() < 4)
            drive(w, 1, 0, 16'h3000 + 16'($urandom_range(0, 15)), 16'h0);
        end
      end
    end
    drive(0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);
    check("arb_count", order_q.size(), 4);
    ptr = 0;
    for (int k = 0; k < 4 && k < order_q.size(); k++) begin
      check($sformatf("arb_%0d", k), order_q[k], FAIR ? ptr : 0);
      ptr = FAIR ? 1 - ptr : 0;
    end
    tick();

    t0 = cyc; n = 0; guard = 0;
    drive(0, 1, 0, 16'h3010, 16'h0);
    while (n < 3 && guard < 100) begin
      tick();
      guard++;
      if (rdy_seen[0]) begin
        rdy_seen[0] = 1'b0;
        rc[n] = cyc;
        n++;
        if (n < 3) drive(0, 1, 0, 16'h3010 + 16'(n), 16'h0);
      end
    end
    drive(0, 0, 0, 16'h0, 16'h0);
    check("b2b_count", n, 3);
    if (n == 3) begin
      check("b2b_first", rc[0] - t0, LAT + 1);
      check("b2b_gap1", rc[1] - rc[0], LAT + 2);
      check("b2b_gap2", rc[2] - rc[1], LAT + 2);
    end
    tick();

    // Reset lands in the second enable cycle of a CPU read.
    drive(0, 1, 0, 16'h3005, 16'h0);
    guard = 0;
    while (!mem_en && guard < 10) begin
      tick();
      guard++;
    end
    check("mid_en_seen", mem_en, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_mem_en", mem_en, 0);
    check("mid_mem_addr", mem_addr, 0);
    check("mid_busy", busy, 0);
    check("mid_cpu_rd", cpu_if.rdata, 0);
    check("mid_dma_rd", dma_if.rdata, 0);
    exp_cpu_rd = '0; exp_dma_rd = '0; en_run = 0; rdy_seen = '0;
    drive(0, 0, 0, 16'h0, 16'h0);
    tick();
    tick();
    check("mid_no_r", rdy_seen, 0);
    rst_n = 1'b1;
    tick();
    xfer(0, 0, 16'h3005, 16'h0, lat);
    check("post_rst_lat", lat, LAT + 1);
    check("post_rst_val", cpu_if.rdata, ref_mem[16'h3005]);

    t0 = cyc; en1 = 0; got = 0; lat = 0;
    cpu1_if.req = 1; cpu1_if.addr = 16'h3001;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (mem1_en) en1++;
      if (cpu1_if.rdy) begin
        got = 1;
        lat = cyc - t0;
      end
    end
    cpu1_if.req = 0;
    check("lat1_done", got, 1);
    check("lat1_lat", lat, LAT1 + 1);
    check("lat1_en", en1, LAT1);
    check("lat1_val", cpu1_if.rdata, tb_mem[16'h3001]);
    tick();

    act[0] = 0; act[1] = 0; wt[0] = 0; wt[1] = 0;
    rdy_seen = '0;
    for (int k = 0; k < 1500; k++) begin
      tick();
      for (int w = 0; w < 2; w++) begin
        if (rdy_seen[w]) begin
          act[w] = 0;
          rdy_seen[w] = 1'b0;
        end
        if (act[w]) begin
          wt[w]++;
          if (wt[w] > 300) begin
            check("rand_timeout", wt[w], 300);
            act[w] = 0;
            drive(w, 0, 0, 16'h0, 16'h0);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          drive(w, 1, 1'($urandom_range(0, 1)),
                16'h3000 + 16'($urandom_range(0, 15)), 16'($urandom));
          act[w] = 1;
          wt[w] = 0;
        end else begin
          drive(w, 0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
